// File: rtl/match_sequencer.sv
// Match controller for the two-player board display.
// Sequences READY -> RUN (<-> PAUSE) -> OVER, runs the BCD MM:SS countdown,
// latches the winner and gates both game blocks through game_run.
module match_sequencer #(
  parameter int unsigned TICK_DIV   = 40_000_000,
  parameter logic [15:0] MATCH_TIME = 16'h0300
) (
  input  logic        pclk,
  input  logic        rstn,
  input  logic        start,
  input  logic        pause,
  input  logic        fail1,
  input  logic        fail2,
  input  logic [7:0]  score1,
  input  logic [7:0]  score2,
  output logic        ifstart,
  output logic        game_run,
  output logic [15:0] timer,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    READY = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  // "Button was low last cycle" flags. They reset to 0, so a button that is
  // already held when reset releases never produces a rising edge.
  logic start_low;
  logic pause_low;
  logic start_rise;
  logic pause_rise;
  logic end_hit;
  logic [1:0] end_winner;

  assign start_rise = start & start_low;
  assign pause_rise = pause & pause_low;

  // One-second BCD decrement: s1 and m1 borrow at 0->9, s10 at 0->5.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = t;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // End-of-match detection in priority order: double fail, single fail, time out.
  always_comb begin
    end_hit    = 1'b1;
    end_winner = 2'b00;
    if (fail1 && fail2) begin
      end_winner = 2'b11;
    end else if (fail1) begin
      end_winner = 2'b10;
    end else if (fail2) begin
      end_winner = 2'b01;
    end else if (timer == 16'h0000) begin
      if (score1 > score2)      end_winner = 2'b01;
      else if (score2 > score1) end_winner = 2'b10;
      else                      end_winner = 2'b11;
    end else begin
      end_hit = 1'b0;
    end
  end

  // Button history for rising-edge detection.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      start_low <= 1'b0;
      pause_low <= 1'b0;
    end else begin
      start_low <= ~start;
      pause_low <= ~pause;
    end
  end

  // Match FSM with prescaler, countdown and registered Moore outputs.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state     <= READY;
      presc     <= '0;
      timer     <= MATCH_TIME;
      ifstart   <= 1'b0;
      game_run  <= 1'b0;
      game_over <= 1'b0;
      winner    <= 2'b00;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        READY: begin
          timer <= MATCH_TIME;
          if (start_rise) begin
            state    <= RUN;
            presc    <= '0;
            ifstart  <= 1'b1;
            game_run <= 1'b1;
          end
        end
        RUN: begin
          // The countdown step completes even on the cycle the match ends.
          if (presc == PRESC_LAST) begin
            presc <= '0;
            if (timer != 16'h0000) begin
              timer <= bcd_dec(timer);
              tick  <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
          if (end_hit) begin
            state     <= OVER;
            game_run  <= 1'b0;
            game_over <= 1'b1;
            winner    <= end_winner;
          end else if (pause_rise) begin
            state    <= PAUSE;
            game_run <= 1'b0;
          end
        end
        PAUSE: begin
          if (pause_rise) begin
            state    <= RUN;
            game_run <= 1'b1;
          end
        end
        OVER: begin
          if (start_rise) begin
            state     <= READY;
            timer     <= MATCH_TIME;
            winner    <= 2'b00;
            game_over <= 1'b0;
            ifstart   <= 1'b0;
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Testbench for match_sequencer with TICK_DIV=4, MATCH_TIME=16'h0010.
// Two extra instances preloaded with 1000 and 0100 share the stimulus.
module tb_match_sequencer;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rstn = 1'b0;
  always #5 pclk = ~pclk;

  logic       start = 1'b0, pause = 1'b0, fail1 = 1'b0, fail2 = 1'b0;
  logic [7:0] score1 = 8'h00, score2 = 8'h00;

  logic        ifstart, game_run, game_over, tick;
  logic [15:0] timer;
  logic [1:0]  winner;

  logic        ifstart_b, game_run_b, game_over_b, tick_b;
  logic [15:0] timer_b;
  logic [1:0]  winner_b;
  logic        ifstart_c, game_run_c, game_over_c, tick_c;
  logic [15:0] timer_c;
  logic [1:0]  winner_c;

  match_sequencer #(.TICK_DIV(4), .MATCH_TIME(16'h0010)) dut (
    .pclk(pclk), .rstn(rstn), .start(start), .pause(pause),
    .fail1(fail1), .fail2(fail2), .score1(score1), .score2(score2),
    .ifstart(ifstart), .game_run(game_run), .timer(timer),
    .game_over(game_over), .winner(winner), .tick(tick)
  );

  match_sequencer #(.TICK_DIV(4), .MATCH_TIME(16'h1000)) dut_b (
    .pclk(pclk), .rstn(rstn), .start(start), .pause(pause),
    .fail1(fail1), .fail2(fail2), .score1(score1), .score2(score2),
    .ifstart(ifstart_b), .game_run(game_run_b), .timer(timer_b),
    .game_over(game_over_b), .winner(winner_b), .tick(tick_b)
  );

  match_sequencer #(.TICK_DIV(4), .MATCH_TIME(16'h0100)) dut_c (
    .pclk(pclk), .rstn(rstn), .start(start), .pause(pause),
    .fail1(fail1), .fail2(fail2), .score1(score1), .score2(score2),
    .ifstart(ifstart_c), .game_run(game_run_c), .timer(timer_c),
    .game_over(game_over_c), .winner(winner_c), .tick(tick_c)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Expected timer values after each decrement starting from 'from'.
  task automatic push_count(input int from, input int to);
    for (int v = from; v >= to; v--) exp_q.push_back(16'((v / 10) * 16 + (v % 10)));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; the button is high across exactly one posedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge pclk);
    pause = 1'b0;
  endtask

  // Wait for n ticks; check spacing (exp_gap>0) and pop the expected timer.
  task automatic run_ticks(input int n, input int exp_gap);
    for (int i = 0; i < n; i++) begin
      int c;
      c = 0;
      do begin
        @(negedge pclk);
        c++;
      end while (!tick && c < 8);
      if (!tick) begin
        check("tick_timeout", 32'(c), 32'(exp_gap));
        return;
      end
      if (exp_gap > 0) check("tick_gap", 32'(c), 32'(exp_gap));
      if (exp_q.size() == 0) check("tick_unexpected", 32'(timer), 32'hffff_ffff);
      else check("tick_timer", 32'(timer), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tick_cnt;

    repeat (3) @(negedge pclk);
    check("rst_timer", 32'(timer), 32'h0010);
    check("rst_ifstart", 32'(ifstart), 32'd0);
    check("rst_game_run", 32'(game_run), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge pclk);

    // Run A: full countdown, P1 wins on score.
    score1 = 8'h12;
    score2 = 8'h07;
    pulse_start();
    check("a_ifstart", 32'(ifstart), 32'd1);
    check("a_game_run", 32'(game_run), 32'd1);
    push_count(9, 0);
    run_ticks(1, 4);
    check("borrow_1000", 32'(timer_b), 32'h0959);
    check("borrow_0100", 32'(timer_c), 32'h0059);
    run_ticks(9, 4);
    check("a_over_delayed", 32'(game_over), 32'd0);
    @(negedge pclk);
    check("a_game_over", 32'(game_over), 32'd1);
    check("a_winner", 32'(winner), 32'h1);
    check("a_game_run", 32'(game_run), 32'd0);
    check("a_timer_zero", 32'(timer), 32'h0000);
    check("a_over_ifstart", 32'(ifstart), 32'd1);
    repeat (3) @(negedge pclk);
    check("a_timer_hold", 32'(timer), 32'h0000);

    // OVER -> READY on start.
    pulse_start();
    check("rdy_timer", 32'(timer), 32'h0010);
    check("rdy_winner", 32'(winner), 32'd0);
    check("rdy_game_over", 32'(game_over), 32'd0);
    check("rdy_ifstart", 32'(ifstart), 32'd0);
    repeat (2) @(negedge pclk);

    // Run B: P1 overflows at 0007.
    pulse_start();
    push_count(9, 7);
    run_ticks(3, 4);
    fail1 = 1'b1;
    @(negedge pclk);
    check("b_game_over", 32'(game_over), 32'd1);
    check("b_winner", 32'(winner), 32'h2);
    check("b_timer", 32'(timer), 32'h0007);
    check("b_game_run", 32'(game_run), 32'd0);
    fail1 = 1'b0;
    fail2 = 1'b1;
    repeat (3) @(negedge pclk);
    check("b_winner_held", 32'(winner), 32'h2);
    check("b_timer_held", 32'(timer), 32'h0007);
    fail2 = 1'b0;
    pulse_start();
    repeat (2) @(negedge pclk);

    // Run C: both overflow together.
    pulse_start();
    push_count(9, 9);
    run_ticks(1, 4);
    fail1 = 1'b1;
    fail2 = 1'b1;
    @(negedge pclk);
    check("c_winner", 32'(winner), 32'h3);
    check("c_game_over", 32'(game_over), 32'd1);
    fail1 = 1'b0;
    fail2 = 1'b0;
    pulse_start();
    repeat (2) @(negedge pclk);

    // Run D: pause at 0005, start ignored while paused, P2 wins on score.
    score1 = 8'h05;
    score2 = 8'h40;
    pulse_start();
    push_count(9, 5);
    run_ticks(5, 4);
    pulse_pause();
    pulse_start();
    tick_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge pclk);
      if (tick) tick_cnt++;
    end
    check("p_no_tick", 32'(tick_cnt), 32'd0);
    check("p_timer", 32'(timer), 32'h0005);
    check("p_ifstart", 32'(ifstart), 32'd1);
    check("p_game_run", 32'(game_run), 32'd0);
    check("p_game_over", 32'(game_over), 32'd0);
    pulse_pause();
    check("p_resume_run", 32'(game_run), 32'd1);
    push_count(4, 0);
    run_ticks(1, 3);
    run_ticks(4, 4);
    @(negedge pclk);
    check("d_game_over", 32'(game_over), 32'd1);
    check("d_winner", 32'(winner), 32'h2);

    // Async reset in OVER drops the winner.
    #2 rstn = 1'b0;
    #1;
    check("ro_winner", 32'(winner), 32'd0);
    check("ro_game_over", 32'(game_over), 32'd0);
    check("ro_timer", 32'(timer), 32'h0010);
    @(negedge pclk);
    rstn = 1'b1;
    repeat (2) @(negedge pclk);

    // Async reset mid-RUN, then start held across reset release.
    pulse_start();
    push_count(9, 9);
    run_ticks(1, 4);
    #2 rstn = 1'b0;
    #1;
    check("rr_timer", 32'(timer), 32'h0010);
    check("rr_ifstart", 32'(ifstart), 32'd0);
    check("rr_game_run", 32'(game_run), 32'd0);
    check("rr_tick", 32'(tick), 32'd0);
    start = 1'b1;
    @(negedge pclk);
    rstn = 1'b1;
    repeat (4) @(negedge pclk);
    check("held_ifstart", 32'(ifstart), 32'd0);
    check("held_game_run", 32'(game_run), 32'd0);
    start = 1'b0;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
